// File: rtl/uart_frame_ctrl_if.sv
// Purpose : byte-stream and frame-event bundle between the UART receiver side and uart_frame_ctrl.
// Latency : none, wires only.
// Backpressure: none; rx_en is a one-cycle strobe and every output is a strobe or a held value.
// Ports   : rx_data/rx_en (byte in); sample_data/sample_valid/sample_idx (sample stream out);
//           frame_cmd/frame_len/frame_start/frame_done/frame_ok (frame status out);
//           err_timeout/err_len (abort strobes out); busy (frame in progress).
interface uart_frame_ctrl_if;
   logic [7:0]  rx_data;
   logic        rx_en;
   logic [15:0] sample_data;
   logic        sample_valid;
   logic [7:0]  sample_idx;
   logic [7:0]  frame_cmd;
   logic [7:0]  frame_len;
   logic        frame_start;
   logic        frame_done;
   logic        frame_ok;
   logic        err_timeout;
   logic        err_len;
   logic        busy;

   // Byte source side: drives the byte stream, observes frame results.
   modport master (
      output rx_data, rx_en,
      input  sample_data, sample_valid, sample_idx, frame_cmd, frame_len,
             frame_start, frame_done, frame_ok, err_timeout, err_len, busy
   );

   // Frame controller side: consumes bytes, produces frame results.
   modport slave (
      input  rx_data, rx_en,
      output sample_data, sample_valid, sample_idx, frame_cmd, frame_len,
             frame_start, frame_done, frame_ok, err_timeout, err_len, busy
   );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Purpose : frame sequencer behind the UART byte receiver: sync hunt, CMD/LEN capture, 16-bit sample stream, checksum and inter-byte timeout.
// Latency : every strobe is registered, asserting exactly one cycle after the rx_en that causes it.
// Backpressure: none; each rx_en is consumed as one byte, downstream must accept every strobe.
// Ports   : clk, rst (sync, active high); bus = uart_frame_ctrl_if.slave carrying the byte input
//           and the sample/frame/error outputs.
module uart_frame_ctrl #(
   parameter logic [7:0]  SYNC0          = 8'h55,
   parameter logic [7:0]  SYNC1          = 8'hAA,
   parameter int unsigned MAX_LEN        = 200,
   parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
   input  logic             clk,
   input  logic             rst,
   uart_frame_ctrl_if.slave bus
);

   localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
   // Terminal count: the idle cycle that would bring the counter to TIMEOUT_CYCLES.
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_SYNC0, S_SYNC1, S_CMD, S_LEN, S_HI, S_LO, S_CSUM
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    hi_q, hi_d;
   logic [7:0]    sum_q, sum_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [15:0]   sample_data_q, sample_data_d;
   logic [7:0]    sample_idx_q, sample_idx_d;
   logic [7:0]    frame_cmd_q, frame_cmd_d;
   logic [7:0]    frame_len_q, frame_len_d;
   logic          sample_valid_q, sample_valid_d;
   logic          frame_start_q, frame_start_d;
   logic          frame_done_q, frame_done_d;
   logic          frame_ok_q, frame_ok_d;
   logic          err_timeout_q, err_timeout_d;
   logic          err_len_q, err_len_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_SYNC0;
         cmd_q          <= '0;
         hi_q           <= '0;
         sum_q          <= '0;
         cnt_q          <= '0;
         tmo_q          <= '0;
         sample_data_q  <= '0;
         sample_idx_q   <= '0;
         frame_cmd_q    <= '0;
         frame_len_q    <= '0;
         sample_valid_q <= 1'b0;
         frame_start_q  <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_ok_q     <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_len_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cmd_q          <= cmd_d;
         hi_q           <= hi_d;
         sum_q          <= sum_d;
         cnt_q          <= cnt_d;
         tmo_q          <= tmo_d;
         sample_data_q  <= sample_data_d;
         sample_idx_q   <= sample_idx_d;
         frame_cmd_q    <= frame_cmd_d;
         frame_len_q    <= frame_len_d;
         sample_valid_q <= sample_valid_d;
         frame_start_q  <= frame_start_d;
         frame_done_q   <= frame_done_d;
         frame_ok_q     <= frame_ok_d;
         err_timeout_q  <= err_timeout_d;
         err_len_q      <= err_len_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cmd_d          = cmd_q;
      hi_d           = hi_q;
      sum_d          = sum_q;
      cnt_d          = cnt_q;
      tmo_d          = '0;          // cleared on every byte and while hunting
      sample_data_d  = sample_data_q;
      sample_idx_d   = sample_idx_q;
      frame_cmd_d    = frame_cmd_q;
      frame_len_d    = frame_len_q;
      frame_ok_d     = frame_ok_q;
      sample_valid_d = 1'b0;
      frame_start_d  = 1'b0;
      frame_done_d   = 1'b0;
      err_timeout_d  = 1'b0;
      err_len_d      = 1'b0;

      if (bus.rx_en) begin
         // A byte arriving on the terminal-count cycle takes priority over the timeout.
         case (state_q)
            S_SYNC0: if (bus.rx_data == SYNC0) state_d = S_SYNC1;
            S_SYNC1: begin
               if (bus.rx_data == SYNC1)      state_d = S_CMD;
               else if (bus.rx_data != SYNC0) state_d = S_SYNC0;
            end
            S_CMD: begin
               cmd_d   = bus.rx_data;
               sum_d   = bus.rx_data;
               state_d = S_LEN;
            end
            S_LEN: begin
               if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
                  err_len_d = 1'b1;
                  state_d   = S_SYNC0;
               end else begin
                  frame_cmd_d   = cmd_q;
                  frame_len_d   = bus.rx_data;
                  frame_start_d = 1'b1;
                  sum_d         = sum_q + bus.rx_data;
                  cnt_d         = 8'd0;
                  state_d       = S_HI;
               end
            end
            S_HI: begin
               hi_d    = bus.rx_data;
               sum_d   = sum_q + bus.rx_data;
               state_d = S_LO;
            end
            S_LO: begin
               sample_data_d  = {hi_q, bus.rx_data};
               sample_idx_d   = cnt_q;
               sample_valid_d = 1'b1;
               sum_d          = sum_q + bus.rx_data;
               if (cnt_q == frame_len_q - 8'd1) begin
                  state_d = S_CSUM;
               end else begin
                  cnt_d   = cnt_q + 8'd1;
                  state_d = S_HI;
               end
            end
            S_CSUM: begin
               frame_done_d = 1'b1;
               frame_ok_d   = (bus.rx_data == sum_q);
               state_d      = S_SYNC0;
            end
            default: state_d = S_SYNC0;
         endcase
      end else if (state_q != S_SYNC0) begin
         if (tmo_q == TMO_LAST) begin
            err_timeout_d = 1'b1;
            state_d       = S_SYNC0;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   assign bus.sample_data  = sample_data_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.sample_idx   = sample_idx_q;
   assign bus.frame_cmd    = frame_cmd_q;
   assign bus.frame_len    = frame_len_q;
   assign bus.frame_start  = frame_start_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.frame_ok     = frame_ok_q;
   assign bus.err_timeout  = err_timeout_q;
   assign bus.err_len      = err_len_q;
   assign bus.busy         = (state_q != S_SYNC0);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Purpose : self-checking bench for uart_frame_ctrl against a byte-buffer reference model.
// Latency : model expects every strobe one cycle after its causing byte.
// Backpressure: none; bytes are driven as single-cycle strobes with chosen idle gaps.
module tb_uart_frame_ctrl;
   localparam int T    = 64;
   localparam int MAXL = 200;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_frame_ctrl_if ufc_if ();

   uart_frame_ctrl #(
      .SYNC0(8'h55), .SYNC1(8'hAA), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ufc_if.slave)
   );

   int n_chk = 0;
   int n_bad = 0;
   int n_start_seen = 0, n_sv_seen = 0, n_done_seen = 0, n_elen_seen = 0, n_tmo_seen = 0;

   // Reference model: frame bytes after the sync pair are kept in a buffer and
   // interpreted by their position in it.
   bit          m_h55, m_in;
   logic [7:0]  fb[$];
   int          m_idle;
   logic [7:0]  m_fcmd, m_flen, m_sidx;
   logic [15:0] m_sdata;
   logic        m_ok;
   bit          e_st, e_sv, e_done, e_elen, e_tmo;
   logic [7:0]  seq[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_h55 = 0; m_in = 0; fb.delete(); m_idle = 0;
      m_fcmd = 0; m_flen = 0; m_sidx = 0; m_sdata = 0; m_ok = 0;
      e_st = 0; e_sv = 0; e_done = 0; e_elen = 0; e_tmo = 0;
   endtask

   task automatic model_step(input bit en, input logic [7:0] d);
      int n, sum;
      e_st = 0; e_sv = 0; e_done = 0; e_elen = 0; e_tmo = 0;
      if (en) begin
         m_idle = 0;
         if (!m_in) begin
            if (m_h55 && d == 8'hAA) begin
               m_in = 1; m_h55 = 0; fb.delete();
            end else begin
               m_h55 = (d == 8'h55);
            end
         end else begin
            fb.push_back(d);
            n = fb.size();
            if (n == 2) begin
               if (d == 0 || int'(d) > MAXL) begin
                  e_elen = 1; m_in = 0;
               end else begin
                  e_st = 1; m_fcmd = fb[0]; m_flen = d;
               end
            end else if (n > 2 && n <= 2 + 2 * int'(m_flen)) begin
               if ((n - 2) % 2 == 0) begin
                  e_sv = 1; m_sdata = {fb[n-2], d}; m_sidx = 8'((n - 2) / 2 - 1);
               end
            end else if (n == 3 + 2 * int'(m_flen)) begin
               sum = 0;
               for (int i = 0; i < n - 1; i++) sum += int'(fb[i]);
               e_done = 1; m_ok = ((sum % 256) == int'(d)); m_in = 0;
            end
         end
      end else if (m_in || m_h55) begin
         m_idle++;
         if (m_idle == T) begin
            e_tmo = 1; m_in = 0; m_h55 = 0; m_idle = 0;
         end
      end
   endtask

   task automatic compare_outputs();
      logic [4:0] got, exp;
      got = {ufc_if.frame_start, ufc_if.sample_valid, ufc_if.frame_done, ufc_if.err_len, ufc_if.err_timeout};
      exp = {e_st, e_sv, e_done, e_elen, e_tmo};
      chk("strobes", 32'(got), 32'(exp));
      chk("evt_exclusive", 32'($countones({got[4], got[2:0]}) <= 1), 32'd1);
      chk("busy", 32'(ufc_if.busy), 32'(m_in || m_h55));
      chk("frame_cmd", 32'(ufc_if.frame_cmd), 32'(m_fcmd));
      chk("frame_len", 32'(ufc_if.frame_len), 32'(m_flen));
      chk("frame_ok", 32'(ufc_if.frame_ok), 32'(m_ok));
      chk("sample_data", 32'(ufc_if.sample_data), 32'(m_sdata));
      chk("sample_idx", 32'(ufc_if.sample_idx), 32'(m_sidx));
      n_start_seen += int'(got[4]);
      n_sv_seen    += int'(got[3]);
      n_done_seen  += int'(got[2]);
      n_elen_seen  += int'(got[1]);
      n_tmo_seen   += int'(got[0]);
   endtask

   task automatic tick(input bit en, input logic [7:0] d);
      ufc_if.rx_en   = en;
      ufc_if.rx_data = d;
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(en, d);
      #1;
      compare_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'($urandom));
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      idle(gap);
      tick(1'b1, b);
   endtask

   task automatic send_seq(input int gmax);
      foreach (seq[i]) send(seq[i], $urandom_range(0, gmax));
      seq.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, 8'h00);
      rst = 1'b0;
   endtask

   function automatic int rgap(input bit harsh);
      int r;
      if (!harsh) return $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      if (r < 70) return $urandom_range(0, 3);
      if (r < 85) return $urandom_range(4, 20);
      if (r < 93) return T - 1;
      return T + $urandom_range(0, 2);
   endfunction

   task automatic send_rand_frame(input bit harsh);
      logic [7:0] cmd, len, b;
      int sum, r;
      r = $urandom_range(0, 99);
      if (r < 3)       len = 8'd0;
      else if (r < 6)  len = 8'd200;
      else if (r < 9)  len = 8'd201;
      else if (r < 11) len = 8'd255;
      else             len = 8'($urandom_range(1, 8));
      cmd = 8'($urandom);
      repeat ($urandom_range(0, 3)) send(8'($urandom), rgap(harsh));
      send(8'h55, rgap(harsh));
      send(8'hAA, rgap(harsh));
      send(cmd, rgap(harsh));
      send(len, rgap(harsh));
      sum = int'(cmd) + int'(len);
      if (len != 0 && int'(len) <= MAXL) begin
         for (int i = 0; i < 2 * int'(len); i++) begin
            b = 8'($urandom);
            sum += int'(b);
            send(b, rgap(harsh));
         end
         b = 8'(sum);
         if ($urandom_range(0, 3) == 0) b = b ^ 8'(1 << $urandom_range(0, 7));
         send(b, rgap(harsh));
      end
   endtask

   initial begin
      int s0, d0, e0, t0;
      ufc_if.rx_en   = 1'b0;
      ufc_if.rx_data = 8'h00;
      model_reset();
      do_reset();
      chk("rst_busy", 32'(ufc_if.busy), 32'd0);
      chk("rst_sample_data", 32'(ufc_if.sample_data), 32'd0);
      chk("rst_frame_cmd", 32'(ufc_if.frame_cmd), 32'd0);
      chk("rst_frame_ok", 32'(ufc_if.frame_ok), 32'd0);
      idle(5);

      // Good frame
      s0 = n_sv_seen; d0 = n_done_seen;
      seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
      send_seq(2);
      idle(3);
      chk("good_samples", 32'(n_sv_seen - s0), 32'd2);
      chk("good_done", 32'(n_done_seen - d0), 32'd1);
      chk("good_ok", 32'(ufc_if.frame_ok), 32'd1);
      chk("good_cmd", 32'(ufc_if.frame_cmd), 32'h01);
      chk("good_len", 32'(ufc_if.frame_len), 32'h02);
      chk("good_last_sample", 32'(ufc_if.sample_data), 32'hABCD);

      // Bad checksum
      s0 = n_sv_seen;
      seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC2};
      send_seq(2);
      idle(3);
      chk("badcs_samples", 32'(n_sv_seen - s0), 32'd2);
      chk("badcs_ok", 32'(ufc_if.frame_ok), 32'd0);

      // Illegal lengths, zero and MAX_LEN+1
      s0 = n_start_seen; e0 = n_elen_seen;
      seq = '{8'h55, 8'hAA, 8'h07, 8'h00};
      send_seq(2);
      idle(1);
      chk("len0_busy", 32'(ufc_if.busy), 32'd0);
      seq = '{8'h55, 8'hAA, 8'h07, 8'hC9};
      send_seq(2);
      idle(1);
      chk("len201_busy", 32'(ufc_if.busy), 32'd0);
      chk("elen_count", 32'(n_elen_seen - e0), 32'd2);
      chk("elen_no_start", 32'(n_start_seen - s0), 32'd0);

      // Timeout mid-frame, then a good frame
      t0 = n_tmo_seen; d0 = n_done_seen;
      seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12};
      send_seq(1);
      idle(T + 10);
      chk("tmo_once", 32'(n_tmo_seen - t0), 32'd1);
      chk("tmo_busy", 32'(ufc_if.busy), 32'd0);
      chk("tmo_no_done", 32'(n_done_seen - d0), 32'd0);
      seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
      send_seq(1);
      idle(2);
      chk("post_tmo_ok", 32'(ufc_if.frame_ok), 32'd1);
      chk("post_tmo_done", 32'(n_done_seen - d0), 32'd1);

      // Sync hunting with a byte landing exactly on the terminal count
      t0 = n_tmo_seen;
      seq = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h01};
      send_seq(2);
      send(8'h00, T - 1);
      send(8'h05, 0);
      send(8'h07, 0);
      idle(2);
      chk("hunt_sample", 32'(ufc_if.sample_data), 32'h0005);
      chk("hunt_ok", 32'(ufc_if.frame_ok), 32'd1);
      chk("edge_no_tmo", 32'(n_tmo_seen - t0), 32'd0);

      // One idle cycle more than allowed aborts
      seq = '{8'h55, 8'hAA, 8'h01};
      send_seq(0);
      idle(T);
      chk("edge_tmo", 32'(n_tmo_seen - t0), 32'd1);

      // Reset after the HI byte
      seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12};
      send_seq(1);
      do_reset();
      chk("midrst_cmd", 32'(ufc_if.frame_cmd), 32'd0);
      chk("midrst_len", 32'(ufc_if.frame_len), 32'd0);
      chk("midrst_busy", 32'(ufc_if.busy), 32'd0);
      s0 = n_sv_seen;
      seq = '{8'h34, 8'hAB, 8'hCD, 8'hC1};
      send_seq(1);
      chk("midrst_ignored", 32'(n_sv_seen - s0), 32'd0);
      seq = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h00, 8'h05, 8'h07};
      send_seq(1);
      idle(2);
      chk("midrst_recover", 32'(ufc_if.frame_ok), 32'd1);

      // Largest legal frame
      seq = '{8'h55, 8'hAA, 8'h3C, 8'hC8};
      send_seq(0);
      for (int i = 0; i < 400; i++) send(8'($urandom), 0);
      send(8'($urandom), 0);
      idle(2);
      chk("maxlen_len", 32'(ufc_if.frame_len), 32'd200);

      // Randomized traffic
      for (int f = 0; f < 40; f++) send_rand_frame(1'b0);
      for (int f = 0; f < 40; f++) send_rand_frame(1'b1);
      idle(T + 5);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Frame-level controller behind the UART byte receiver: consumes the rx_data/rx_en byte stream and sequences the capture of one sample frame.
- Hunts for the sync pattern, latches command and length, and streams 16-bit samples to the peak-search buffer.
- Validates each frame with a checksum and an inter-byte timeout.
- Outputs commit/abort strobes so downstream logic only acts on good frames.

Parameters:
- SYNC0, 8'h55, first sync byte.
- SYNC1, 8'hAA, second sync byte.
- MAX_LEN, 200, maximum sample count per frame; legal range 1..255.
- TIMEOUT_CYCLES, 50_000, idle clk cycles allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_en=1.
- rx_en  in  1  one-cycle byte strobe from the UART receiver.
- sample_data  out  16  assembled sample, big-endian (high byte first).
- sample_valid  out  1  one-cycle strobe; sample_data and sample_idx valid.
- sample_idx  out  8  index of the sample within the frame, 0..LEN-1.
- frame_cmd  out  8  command byte of the current/last frame.
- frame_len  out  8  sample count of the current/last frame.
- frame_start  out  1  one-cycle pulse when a legal LEN is accepted.
- frame_done  out  1  one-cycle pulse after the checksum byte.
- frame_ok  out  1  qualifies frame_done: 1 = checksum match.
- err_timeout  out  1  one-cycle pulse on inter-byte timeout abort.
- err_len  out  1  one-cycle pulse on illegal LEN abort.
- busy  out  1  high in every state except S_SYNC0.

Behaviour:
- Frame format: SYNC0, SYNC1, CMD, LEN, then LEN×(HI, LO), then CSUM. CSUM = 8-bit sum modulo 256 of CMD, LEN and all payload bytes.
- Reset values: all outputs 0; state S_SYNC0; sum, timeout counter and sample counter 0.
- States advance only on rx_en=1, except timeout.
- S_SYNC0: byte==SYNC0 -> S_SYNC1; otherwise stay.
- S_SYNC1: byte==SYNC1 -> S_CMD; byte==SYNC0 -> stay in S_SYNC1; otherwise -> S_SYNC0.
- S_CMD: latch byte into internal cmd register; sum <= byte -> S_LEN.
- S_LEN:
  - byte==0 or byte>MAX_LEN -> err_len pulse -> S_SYNC0.
  - else frame_cmd<=cmd, frame_len<=byte, frame_start pulse, sum += byte, sample counter <= 0 -> S_HI.
  - frame_cmd/frame_len stay stable until the next frame_start.
- S_HI: hold byte in hi register; sum += byte -> S_LO.
- S_LO: sample_data <= {hi, byte}; sample_idx <= counter; sample_valid pulse; sum += byte.
  - If counter == frame_len-1 -> S_CSUM.
  - Else counter++ -> S_HI.
- S_CSUM: frame_done pulse; frame_ok <= (byte == sum[7:0]) -> S_SYNC0.
  - frame_ok holds its value until the next frame_done.
- Latency: every strobe output (sample_valid, frame_start, frame_done, err_len) is registered and asserts exactly 1 cycle after the rx_en that causes it.
- Timeout:
  - The counter clears on every rx_en and while in S_SYNC0; otherwise it increments.
  - Reaching TIMEOUT_CYCLES -> err_timeout pulse, state -> S_SYNC0, no frame_done.
  - If rx_en and the terminal count occur in the same cycle, the byte wins: the counter clears and no timeout fires.
- Sample integrity: samples are streamed before checksum verification. Downstream commits only on frame_done && frame_ok, and discards on frame_done && !frame_ok, err_timeout, or a new frame_start.
- Width rules:
  - sum is 8-bit, wraps silently.
  - The sample counter is 8-bit; it never exceeds MAX_LEN-1, so it cannot wrap.
- Mutual exclusion: at most one of frame_start, frame_done, err_len, err_timeout is high in any cycle.
- Reset mid-frame: immediate return to S_SYNC0 on the next clk. All strobes drop to 0. frame_cmd, frame_len and frame_ok clear to 0. No error pulse is generated.
- rx_en held high for multiple cycles: each cycle counts as a separate byte. The upstream UART guarantees single-cycle strobes.

Test Plan:
- Good frame: bytes 55 AA 01 02 12 34 AB CD C1 -> frame_start with cmd=01, len=02; sample_valid twice (1234 idx0, ABCD idx1); frame_done=1, frame_ok=1.
- Bad checksum: same frame with last byte C2 -> both samples still strobed; frame_done=1, frame_ok=0.
- Illegal length: 55 AA 07 00, then 55 AA 07 C9 (C9 > MAX_LEN=200) -> two err_len pulses, no frame_start, busy low after each.
- Timeout: 55 AA 01 02 12, then silence for TIMEOUT_CYCLES -> err_timeout exactly once, busy=0, no frame_done. A following good frame then decodes normally.
- Sync hunting: 00 55 55 AA 01 01 00 05 07 -> 0005 at idx0; frame_ok=1 (01+01+00+05=07).
- Reset mid-frame: rst=1 for 1 cycle after the S_HI byte -> all outputs 0; the remainder of the frame is ignored until a fresh 55 AA.
